// File: rtl/jtframe_joydb15_pkg.sv
// Shared types and constants for the DB15 dual-joystick adapter scanner.
package jtframe_joydb15_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned JOY_W   = FRAME_W / 2;

  // Line reads all-low for the whole frame: adapter missing or shorted
  localparam logic [FRAME_W-1:0] RAW_ABSENT = 32'hFFFF_FFFF;

  localparam int unsigned BIT_RIGHT = 0;
  localparam int unsigned BIT_LEFT  = 1;
  localparam int unsigned BIT_DOWN  = 2;
  localparam int unsigned BIT_UP    = 3;

  typedef enum logic [2:0] {
    ST_GAP_W,
    ST_LOAD,
    ST_SETUP,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  // Serial bits 0..15 belong to player 1, 16..31 to player 2
  typedef struct packed {
    logic [JOY_W-1:0] p2;
    logic [JOY_W-1:0] p1;
  } joy_frame_t;

endpackage

// File: rtl/jtframe_joydb15_tick.sv
// Free-running tick divider: one-cycle tick every DIV enabled clock cycles.
module jtframe_joydb15_tick #(
  parameter int unsigned DIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(DIV - 1));

  // Counter holds while disabled so the tick phase is preserved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtframe_joydb15_scan.sv
// DB15 adapter scanner: shifts a 32-bit frame out of the adapter chain and
// publishes two joystick words once two consecutive captures agree.
module jtframe_joydb15_scan
  import jtframe_joydb15_pkg::*;
#(
  parameter int unsigned CLKDIV = 24,
  parameter int unsigned GAP    = 64
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  output logic             JOY_CLK,
  output logic             JOY_LOAD,
  input  logic             JOY_DATA,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             present,
  output logic             frame_done
);

  localparam int unsigned GAP_CNT_W = 10;
  localparam int unsigned IDX_W     = 5;

  state_t               state;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [FRAME_W-1:0]   raw;
  logic [FRAME_W-1:0]   prev;
  logic [1:0]           data_sync;
  joy_frame_t           raw_f;
  logic                 tick_c;
  logic                 tick_en_c;

  assign raw_f     = raw;
  assign tick_en_c = (state != ST_DONE);

  jtframe_joydb15_tick #(
    .DIV (CLKDIV)
  ) u_tick (
    .clk    (clk_sys),
    .rst_n  (rst_n),
    .en     (tick_en_c),
    .tick_c (tick_c)
  );

  // Two-flop synchroniser for the asynchronous adapter data line
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_sync <= 2'b11;
    end else begin
      data_sync <= {data_sync[0], JOY_DATA};
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP_W;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      raw        <= '0;
      prev       <= '0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      present    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_GAP_W: begin
          if (tick_c) begin
            if (gap_cnt == GAP_CNT_W'(GAP)) begin
              state    <= ST_LOAD;
              JOY_LOAD <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_CNT_W'(1);
            end
          end
        end
        ST_LOAD: begin
          if (tick_c) begin
            state    <= ST_SETUP;
            JOY_LOAD <= 1'b1;
            bit_idx  <= '0;
          end
        end
        ST_SETUP: begin
          if (tick_c) begin
            state <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          // Sample after a full low half-period, as JOY_CLK rises
          if (tick_c) begin
            raw[bit_idx] <= ~data_sync[1];
            JOY_CLK      <= 1'b1;
            state        <= ST_CLK_HI;
          end
        end
        ST_CLK_HI: begin
          if (tick_c) begin
            JOY_CLK <= 1'b0;
            if (bit_idx == IDX_W'(FRAME_W - 1)) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              state   <= ST_CLK_LO;
            end
          end
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          prev       <= raw;
          state      <= ST_GAP_W;
          // Restart at 1 so steady-state gaps are GAP ticks; after reset the
          // counter starts at 0 and the first gap is one tick longer.
          gap_cnt    <= GAP_CNT_W'(1);
          if (raw == prev) begin
            if (raw == RAW_ABSENT) begin
              present   <= 1'b0;
              joystick1 <= '0;
              joystick2 <= '0;
            end else begin
              present   <= 1'b1;
              joystick1 <= raw_f.p1;
              joystick2 <= raw_f.p2;
            end
          end
        end
        default: begin
          state <= ST_GAP_W;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_joydb15_scan.sv
// Bench for jtframe_joydb15_scan: 74HC165-style adapter model, frame-timing
// and double-capture reference model checked on every cycle.
module tb_jtframe_joydb15_scan;
  import jtframe_joydb15_pkg::*;

  localparam int CLKDIV  = 24;
  localparam int GAP     = 64;
  localparam int PERIOD  = (GAP + 2 + 64) * CLKDIV + 1;
  localparam int LOAD_AT = GAP * CLKDIV;
  localparam int CLK_AT  = (GAP + 2) * CLKDIV;
  localparam int CLK_END = CLK_AT + 64 * CLKDIV;
  localparam int BOUND   = 4000;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b1;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        present;
  logic        frame_done;

  logic [31:0] pat    = 32'h0000_0001;
  logic        absent = 1'b0;
  logic [31:0] sr     = '0;

  int n_chk  = 0;
  int n_fail = 0;

  jtframe_joydb15_scan #(
    .CLKDIV (CLKDIV),
    .GAP    (GAP)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .present    (present),
    .frame_done (frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Adapter: parallel load while JOY_LOAD low, shift on JOY_CLK rise, active-low wire
  always @(negedge JOY_LOAD or posedge JOY_CLK) begin
    if (!JOY_LOAD) sr <= pat;
    else           sr <= {1'b0, sr[31:1]};
  end
  assign JOY_DATA = absent ? 1'b0 : ~sr[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc;
  logic [31:0] mprev;
  logic [15:0] mj1, mj2;
  logic        mpres;
  int          rises, last_rise, last_fd;
  logic        fd_seen, load_seen, clk_q, load_q;

  always @(negedge clk_sys) begin
    int          d, m;
    logic        exp_fd, exp_load, exp_clk;
    logic [31:0] fr;
    if (!rst_n) begin
      cyc = 0; mprev = '0; mj1 = '0; mj2 = '0; mpres = 1'b0;
      rises = 0; fd_seen = 1'b0; load_seen = 1'b0; clk_q = 1'b0; load_q = 1'b1;
      check("reset", 64'({JOY_LOAD, JOY_CLK, frame_done, present, joystick2, joystick1}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    end else begin
      cyc++;
      if (cyc >= CLKDIV) begin
        d = (cyc - CLKDIV) % PERIOD;
        m = (cyc - CLKDIV) / PERIOD;
      end else begin
        d = -1;
        m = 0;
      end
      exp_fd   = (d == 0) && (m >= 1);
      exp_load = !(d >= LOAD_AT && d < LOAD_AT + CLKDIV);
      exp_clk  = (d >= CLK_AT) && (d < CLK_END) && (((d - CLK_AT) / CLKDIV) % 2 == 1);
      if (exp_fd) begin
        fr = absent ? RAW_ABSENT : pat;
        if (fr == mprev) begin
          mpres = (fr != RAW_ABSENT);
          mj1   = mpres ? fr[15:0]  : 16'h0;
          mj2   = mpres ? fr[31:16] : 16'h0;
        end
        mprev = fr;
      end
      check("cycle", 64'({JOY_LOAD, JOY_CLK, frame_done, present, joystick2, joystick1}),
            64'({exp_load, exp_clk, exp_fd, mpres, mj2, mj1}));
      if (JOY_CLK && !clk_q) begin
        if (rises > 0) check("jclk_period", 64'(cyc - last_rise), 64'(48));
        last_rise = cyc;
        rises++;
      end
      if (!JOY_LOAD && load_q && !load_seen) begin
        check("first_load", 64'(cyc), 64'(1560));
        load_seen = 1'b1;
      end
      if (frame_done) begin
        check("rises_per_frame", 64'(rises), 64'(32));
        if (fd_seen) check("fd_spacing", 64'(cyc - last_fd), 64'(3121));
        last_fd = cyc;
        fd_seen = 1'b1;
        rises   = 0;
      end
      clk_q  = JOY_CLK;
      load_q = JOY_LOAD;
    end
  end

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (frame_done !== 1'b1 && n < BOUND);
    check("fd_wait", 64'(frame_done), 64'(1));
  endtask

  task automatic set_stim(input logic [31:0] p, input logic a);
    @(posedge clk_sys);
    pat    = p;
    absent = a;
  endtask

  initial begin
    logic [31:0] rp;
    int          n;
    logic        jq;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk_sys);
    #1 rst_n = 1'b1;

    // Pattern capture: first frame differs from reset prev, second confirms
    wait_fd();
    check("f1_j1", 64'(joystick1), 64'(16'h0000));
    check("f1_present", 64'(present), 64'(0));
    wait_fd();
    check("f2_j1", 64'(joystick1), 64'(16'h0001));
    check("f2_j2", 64'(joystick2), 64'(16'h0000));
    check("f2_present", 64'(present), 64'(1));
    check("f2_dirs", 64'({joystick1[BIT_UP], joystick1[BIT_DOWN], joystick1[BIT_LEFT],
                          joystick1[BIT_RIGHT]}), 64'(4'b0001));

    // Filter: alternating frames never publish
    set_stim(32'h0010_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_fd();
      check("filter_hold", 64'({joystick2, joystick1}), 64'(32'h0000_0001));
      set_stim((i % 2 == 0) ? 32'h0 : 32'h0010_0000, 1'b0);
    end
    wait_fd();
    check("steady_1", 64'({joystick2, joystick1}), 64'(32'h0000_0001));
    wait_fd();
    check("steady_j2", 64'(joystick2), 64'(16'h0010));
    check("steady_j1", 64'(joystick1), 64'(16'h0000));

    // Absent adapter clears previously held 00F0 words
    set_stim(32'h00F0_00F0, 1'b0);
    wait_fd();
    wait_fd();
    check("f0_words", 64'({joystick2, joystick1}), 64'(32'h00F0_00F0));
    set_stim(32'h00F0_00F0, 1'b1);
    wait_fd();
    check("absent_1", 64'({present, joystick2, joystick1}), 64'({1'b1, 32'h00F0_00F0}));
    wait_fd();
    check("absent_2", 64'({present, joystick2, joystick1}), 64'(0));

    // Randomised frames: repeat, new pattern or toggle adapter presence
    for (int i = 0; i < 6; i++) begin
      rp = pat;
      n  = int'($urandom_range(0, 3));
      if (n == 2) begin
        rp = $urandom();
        if (rp == RAW_ABSENT) rp = 32'h1234_5678;
      end
      set_stim(rp, (n == 3) ? !absent : absent);
      wait_fd();
    end

    // Reset mid-frame
    set_stim(32'h0003_0005, 1'b0);
    wait_fd();
    wait_fd();
    check("pre_rst", 64'({joystick2, joystick1}), 64'(32'h0003_0005));
    n = 0;
    do begin @(negedge clk_sys); n++; end while (JOY_LOAD !== 1'b0 && n < BOUND);
    check("load_wait", 64'(JOY_LOAD), 64'(0));
    n = 0;
    jq = JOY_CLK;
    for (int k = 0; k < BOUND && n < 17; k++) begin
      @(negedge clk_sys);
      if (JOY_CLK && !jq) n++;
      jq = JOY_CLK;
    end
    check("bit17_wait", 64'(n), 64'(17));
    @(posedge clk_sys);
    #3 rst_n = 1'b0;
    #1 check("rst_async", 64'({JOY_LOAD, JOY_CLK, present, joystick2, joystick1}),
             64'({1'b1, 1'b0, 1'b0, 32'h0}));
    repeat (5) @(negedge clk_sys);
    #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (frame_done !== 1'b1 && n < BOUND);
    check("first_fd_after_rst", 64'(n), 64'(3145));
    check("post_rst_hold", 64'({present, joystick2, joystick1}), 64'(0));
    wait_fd();
    check("post_rst_j", 64'({present, joystick2, joystick1}), 64'({1'b1, 32'h0003_0005}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
